// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
// The bit counter runs 0..WIDTH-1, so it needs $clog2(WIDTH) bits.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder: sum is the XOR of the inputs, carry is their majority.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic c
);

    assign sum = a ^ b ^ cin;
    assign c   = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures a, b, cin on start, adds one bit per cycle LSB
// first, then pulses done with the registered sum and carry-out.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             fa_sum_s;
    logic             fa_c_s;

    fa_bit u_fa_bit (
        .a   (a_r[0]),
        .b   (b_r[0]),
        .cin (carry_r),
        .sum (fa_sum_s),
        .c   (fa_c_s)
    );

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_SHIFT);
            done_r  <= (next_state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
                    carry_r <= fa_c_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        cout_r <= fa_c_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus queues expected results,
// a negedge monitor checks each done pulse for value, timing and busy length.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic [31:0]  due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           checks = 0;
    int           errors = 0;
    int unsigned  cyc = 0;
    int           busy_cnt = 0;
    exp_t         q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sum", {24'd0, sum}, {24'd0, e.sum});
                chk("cout", {31'd0, cout}, {31'd0, e.cout});
                chk("done_cycle", cyc, e.due);
                chk("busy_cycles", busy_cnt, W);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                busy_cnt = 0;
            end
        end
    end

    // Call at a negedge while IDLE; start is sampled by the next posedge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W-1:0] s, input logic c);
        a = av; b = bv; cin = cv; start = 1'b1;
        q.push_back(exp_t'{s, c, cyc + 1 + W});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 32'd0);
        q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   ref_sum;
        int unsigned  acc;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);

        // Start raised together with reset release: first edge must accept it.
        rst_n = 1'b1;
        issue(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_sum", {24'd0, sum}, 32'h8D);
        chk("hold_cout", {31'd0, cout}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1); drain();
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1); drain();
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1); drain();
        issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0); drain();

        // Start and operand changes during SHIFT must not disturb the result.
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the 4th SHIFT cycle: no done may ever follow.
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        // Start held high: back-to-back operations, one IDLE cycle apart.
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        a = ra; b = rb; cin = rc; start = 1'b1;
        acc = cyc + 1;
        q.push_back(exp_t'{ref_sum[W-1:0], ref_sum[W], acc + W});
        for (int i = 0; i < 1000; i++) begin
            repeat (3) @(negedge clk);
            if (i < 999) begin
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
                a = ra; b = rb; cin = rc;
                acc = acc + W + 2;
                q.push_back(exp_t'{ref_sum[W-1:0], ref_sum[W], acc + W});
            end else begin
                start = 1'b0;
            end
            repeat (W - 1) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
